hazard_sequencer: RTL and testbench
===================================

Name: hazard_sequencer

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Drives stall, flush and hold controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three hazard types: load-use, taken branch (resolved in EX) and jump (decoded in ID).
- Sequences multi-cycle data-memory waits with a timeout FSM, and keeps saturating stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive data-memory wait cycles before the error trap.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ifid_rs  in  5  rs field of the instruction in ID
- ifid_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  instruction in ID reads rt as a source
- id_jump  in  1  jump decoded in ID
- idex_memread  in  1  MemRead of the instruction in EX
- idex_rt  in  5  destination rt of the instruction in EX
- ex_branch_taken  in  1  beq/bne resolved taken in EX
- exmem_memaccess  in  1  MemRead or MemWrite active in MEM
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads zeros
- idex_flush  out  1  ID/EX loads zeros (bubble)
- idex_hold  out  1  ID/EX keeps its value
- exmem_hold  out  1  EX/MEM keeps its value
- memwb_bubble  out  1  MEM/WB loads zeros
- mem_err  out  1  memory timeout trap, sticky
- stall_cnt  out  CNT_W  cycles with pc_write=0
- flush_cnt  out  CNT_W  cycles with ifid_flush=1

Behaviour:
- FSM states:
  - RUN (reset state)
  - MEM_WAIT
  - ERR
- Registers:
  - state
  - wait_cnt (width clog2(MEM_TIMEOUT)+1)
  - stall_cnt, flush_cnt
- Control outputs are combinational (Mealy) from state and inputs.
- Defaults: pc_write=1, ifid_write=1; all other control outputs 0.
- memwait = exmem_memaccess & ~dmem_ready.
- lu = idex_memread & (idex_rt!=0) & ((idex_rt==ifid_rs) | (id_uses_rt & idex_rt==ifid_rt)).
- Priority in RUN and MEM_WAIT, first match wins:
  1. memwait: pc_write=0, ifid_write=0, idex_hold=1, exmem_hold=1, memwb_bubble=1.
  2. ex_branch_taken: ifid_flush=1, idex_flush=1, pc_write=1.
  3. lu: pc_write=0, ifid_write=0, idex_flush=1. Exactly one bubble per load-use; the next cycle re-evaluates with the load in MEM.
  4. id_jump: ifid_flush=1, pc_write=1.
- Transitions:
  - RUN, memwait: next MEM_WAIT, wait_cnt<=1.
  - MEM_WAIT, memwait, wait_cnt<MEM_TIMEOUT: stay, wait_cnt+1.
  - MEM_WAIT, memwait, wait_cnt==MEM_TIMEOUT: next ERR.
  - MEM_WAIT, ~memwait: next RUN, wait_cnt<=0. The same cycle applies priorities 2-4.
  - ERR: pc_write=0, ifid_write=0, idex_hold=1, exmem_hold=1, memwb_bubble=1, mem_err=1. Leaves only on rst.
- Simultaneous events:
  - Branch and load-use together: the branch wins and no stall occurs; the dependent instruction is flushed anyway.
  - Branch and jump together: the branch wins.
  - A hold cycle (priority 1) masks all flushes. A branch pending in EX is held and re-evaluated when the wait ends.
- Counters:
  - stall_cnt increments on every cycle with pc_write=0 (including ERR).
  - flush_cnt increments on every cycle with ifid_flush=1.
  - Both saturate at all-ones.
- Reset:
  - rst=1 in any state, including mid-MEM_WAIT or ERR: next state RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0.
  - While rst=1: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, idex_hold=0, exmem_hold=0, memwb_bubble=0, mem_err=0. Counters do not increment.
- Register $zero: a load to $0 never causes a load-use stall.

Test Plan:
- Load-use: idex_memread=1, idex_rt=8, ifid_rs=8 -> one cycle with pc_write=0, ifid_write=0, idex_flush=1. Next cycle with idex_memread=0 -> defaults; stall_cnt=1.
- Rt-only dependence: idex_rt=9, ifid_rt=9, id_uses_rt=0 -> no stall. Same with id_uses_rt=1 -> stall. idex_rt=0 -> never stalls.
- Branch vs load-use: ex_branch_taken=1 with lu=1 -> ifid_flush=1, idex_flush=1, pc_write=1; flush_cnt=1, stall_cnt=0.
- Memory wait: exmem_memaccess=1, dmem_ready=0 for 3 cycles, then 1 -> 3 hold cycles, state returns to RUN, stall_cnt=3. A pending id_jump gets ifid_flush in the ready cycle.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> ERR reached after the 5th hold cycle, mem_err=1 sticky. Then rst=1 for 1 cycle -> RUN, counters 0, mem_err=0.
- Saturation: CNT_W=4, 20 consecutive load-use stalls -> stall_cnt stays at 15.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller for the 5-stage MIPS core: load-use, branch and jump
// hazards, data-memory wait sequencing with timeout trap, and stall/flush counters.
//
// state    | meaning
// RUN      | normal issue, hazards resolved by priority
// MEM_WAIT | data memory stalled, counting consecutive wait cycles
// ERR      | memory timeout trap, pipeline frozen until rst
module hazard_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             ex_branch_taken,
    input  logic             exmem_memaccess,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic             memwb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int WCW = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    state_t         state, state_nxt;
    logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
    logic           memwait;
    logic           lu;

    assign memwait = exmem_memaccess & ~dmem_ready;
    // A load targeting $zero never creates a dependence.
    assign lu = idex_memread & (idex_rt != 5'd0) &
                ((idex_rt == ifid_rs) | (id_uses_rt & (idex_rt == ifid_rt)));

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        idex_hold    = 1'b0;
        exmem_hold   = 1'b0;
        memwb_bubble = 1'b0;
        mem_err      = 1'b0;
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;

        if (rst) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
        end else if (state == ERR) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_hold    = 1'b1;
            exmem_hold   = 1'b1;
            memwb_bubble = 1'b1;
            mem_err      = 1'b1;
        end else if (memwait) begin
            // Holding masks every flush; a taken branch stays in EX and is re-evaluated.
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_hold    = 1'b1;
            exmem_hold   = 1'b1;
            memwb_bubble = 1'b1;
            if (state == RUN) begin
                state_nxt    = MEM_WAIT;
                wait_cnt_nxt = WCW'(1);
            end else if (wait_cnt == WCW'(MEM_TIMEOUT)) begin
                state_nxt = ERR;
            end else begin
                wait_cnt_nxt = wait_cnt + WCW'(1);
            end
        end else begin
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
            if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (lu) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end else if (id_jump) begin
                ifid_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        state    <= state_nxt;
        wait_cnt <= wait_cnt_nxt;
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_write && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (ifid_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: directed hazard scenarios followed by
// randomized traffic, checked against a rule-level reference model.
module tb_hazard_sequencer;
    localparam int MT = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    ifid_rs, ifid_rt, idex_rt;
    logic          id_uses_rt, id_jump, idex_memread, ex_branch_taken;
    logic          exmem_memaccess, dmem_ready;
    logic          pc_write, ifid_write, ifid_flush, idex_flush;
    logic          idex_hold, exmem_hold, memwb_bubble, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_sequencer #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .ex_branch_taken(ex_branch_taken),
        .exmem_memaccess(exmem_memaccess), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .idex_hold(idex_hold), .exmem_hold(exmem_hold),
        .memwb_bubble(memwb_bubble), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ctl;
        int         sc;
        int         fc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model state: sticky trap, consecutive wait cycles, counter values.
    bit m_err;
    int m_waits;
    int m_stall;
    int m_flush;

    task automatic clear_in();
        ifid_rs = 0; ifid_rt = 0; idex_rt = 0;
        id_uses_rt = 0; id_jump = 0; idex_memread = 0; ex_branch_taken = 0;
        exmem_memaccess = 0; dmem_ready = 1; rst = 0;
    endtask

    // Expected controls packed as {pc_write, ifid_write, ifid_flush, idex_flush,
    // idex_hold, exmem_hold, memwb_bubble, mem_err}.
    task automatic run_cycle();
        exp_t e;
        bit   mw, lu;
        mw = exmem_memaccess && !dmem_ready;
        lu = idex_memread && idex_rt != 0 &&
             (idex_rt == ifid_rs || (id_uses_rt && idex_rt == ifid_rt));
        e.sc = m_stall;
        e.fc = m_flush;
        if (rst)                  e.ctl = 8'b0011_0000;
        else if (m_err)           e.ctl = 8'b0000_1111;
        else if (mw)              e.ctl = 8'b0000_1110;
        else if (ex_branch_taken) e.ctl = 8'b1111_0000;
        else if (lu)              e.ctl = 8'b0001_0000;
        else if (id_jump)         e.ctl = 8'b1110_0000;
        else                      e.ctl = 8'b1100_0000;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (rst) begin
            m_err = 0; m_waits = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!e.ctl[7] && m_stall < CMAX) m_stall++;
            if (e.ctl[5] && m_flush < CMAX) m_flush++;
            if (!m_err) begin
                if (mw) begin
                    m_waits++;
                    if (m_waits > MT) m_err = 1;
                end else begin
                    m_waits = 0;
                end
            end
        end
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1;
        run_cycle();
        rst = 0;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ctl", {pc_write, ifid_write, ifid_flush, idex_flush,
                        idex_hold, exmem_hold, memwb_bubble, mem_err}, e.ctl);
            chk("stall_cnt", 8'(stall_cnt), 8'(e.sc));
            chk("flush_cnt", 8'(flush_cnt), 8'(e.fc));
        end
    end

    initial begin
        clear_in();
        rst = 1;
        m_err = 0; m_waits = 0; m_stall = 0; m_flush = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Load-use on rs, then a clean cycle.
        idex_memread = 1; idex_rt = 8; ifid_rs = 8;
        run_cycle();
        clear_in();
        run_cycle();

        // rt-only dependence, with and without id_uses_rt; then a $zero load.
        idex_memread = 1; idex_rt = 9; ifid_rt = 9; ifid_rs = 3; id_uses_rt = 0;
        run_cycle();
        id_uses_rt = 1;
        run_cycle();
        idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
        run_cycle();
        clear_in();

        // Branch beats load-use and jump.
        do_reset();
        idex_memread = 1; idex_rt = 8; ifid_rs = 8; ex_branch_taken = 1;
        run_cycle();
        id_jump = 1;
        run_cycle();
        clear_in();
        run_cycle();

        // Three-cycle memory wait with a pending jump and branch, then ready.
        do_reset();
        exmem_memaccess = 1; dmem_ready = 0; id_jump = 1;
        repeat (3) run_cycle();
        dmem_ready = 1;
        run_cycle();
        dmem_ready = 0; ex_branch_taken = 1;
        repeat (2) run_cycle();
        dmem_ready = 1;
        run_cycle();
        clear_in();
        run_cycle();

        // Timeout into the sticky trap, then recovery through reset.
        exmem_memaccess = 1; dmem_ready = 0;
        repeat (MT + 3) run_cycle();
        clear_in();
        repeat (2) run_cycle();
        do_reset();
        repeat (2) run_cycle();

        // Counter saturation on back-to-back load-use stalls.
        idex_memread = 1; idex_rt = 5; ifid_rs = 5;
        repeat (20) run_cycle();
        ex_branch_taken = 1;
        repeat (20) run_cycle();
        clear_in();

        // Randomized traffic over a small register set so hazards collide often.
        for (int i = 0; i < 3000; i++) begin
            rst             = ($urandom_range(0, 59) == 0);
            ifid_rs         = 5'($urandom_range(0, 3));
            ifid_rt         = 5'($urandom_range(0, 3));
            idex_rt         = 5'($urandom_range(0, 3));
            id_uses_rt      = 1'($urandom_range(0, 1));
            id_jump         = ($urandom_range(0, 3) == 0);
            idex_memread    = ($urandom_range(0, 1) == 0);
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            exmem_memaccess = ($urandom_range(0, 2) == 0);
            dmem_ready      = ($urandom_range(0, 9) < 6);
            run_cycle();
        end

        clear_in();
        @(negedge clk);
        #1;
        checks++;
        if (q.size() == 0) passes++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
